// File: rtl/vdc_host_port_if.sv
// vdc_host_port_if: CPU bus, register-commit and VRAM handshake bundle for
// the VDC host port. The slave modport is the host port; the master modport
// is whatever sits around it (CPU, register file, VRAM arbiter, IRQ sources).
interface vdc_host_port_if #(
    parameter int AR_W     = 5,
    parameter int IRQ_SRCS = 4
);
    // CPU side
    logic                CS_n;
    logic                RD_n;
    logic                WR_n;
    logic [1:0]          A;
    logic [7:0]          D_in;
    logic [7:0]          D_out;
    logic                BUSY_n;
    logic                IRQ_n;
    logic [IRQ_SRCS-1:0] irq_src;
    // register commit
    logic                reg_wr;
    logic [AR_W-1:0]     reg_addr;
    logic [15:0]         reg_data;
    // VRAM write FIFO head toward the arbiter
    logic                vram_wr_req;
    logic [15:0]         vram_wr_data;
    logic                vram_wr_ack;
    // VRAM read handshake
    logic                vram_rd_req;
    logic                vram_rd_ack;
    logic [15:0]         vram_rd_data;

    modport slave (
        input  CS_n, RD_n, WR_n, A, D_in, irq_src, vram_wr_ack, vram_rd_ack, vram_rd_data,
        output D_out, BUSY_n, IRQ_n, reg_wr, reg_addr, reg_data, vram_wr_req, vram_wr_data,
               vram_rd_req
    );

    modport master (
        output CS_n, RD_n, WR_n, A, D_in, irq_src, vram_wr_ack, vram_rd_ack, vram_rd_data,
        input  D_out, BUSY_n, IRQ_n, reg_wr, reg_addr, reg_data, vram_wr_req, vram_wr_data,
               vram_rd_req
    );
endinterface

// File: rtl/vdc_host_port.sv
// vdc_host_port: CPU-side host port of the VDC.
// Decodes the 2-bit A selector, owns the address register and LSB latch,
// commits 16-bit register writes, buffers VRAM writes in a small FIFO,
// fetches VRAM reads through a req/ack handshake, and aggregates IRQs.
// Optional feature macro: VDC_HOST_AUTOINC_EN (address auto-increment after
// each data MSB write commit, except on the VRAM write streaming register).
module vdc_host_port #(
    parameter int NUM_REGS    = 32,
    parameter int WFIFO_DEPTH = 4,
    parameter int IRQ_SRCS    = 4,
    parameter int VWR_REG     = 2,
    parameter int VRR_REG     = 2,
    parameter int IRQ_EN_REG  = 5
) (
    input logic             clock,
    input logic             reset_n,
    vdc_host_port_if.slave  bus
);
    localparam int AR_W  = $clog2(NUM_REGS);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        A_STATUS_REG = 2'd0,
        A_ADDR_REG   = 2'd1,
        A_DATA_LSB   = 2'd2,
        A_DATA_MSB   = 2'd3
    } a_sel_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

    // state
    logic                rd_seen_q, rd_seen_d;
    logic                wr_seen_q, wr_seen_d;
    logic [AR_W-1:0]     ar_q, ar_d;
    logic [7:0]          lsb_q, lsb_d;
    logic [15:0]         rdlat_q, rdlat_d;
    logic [IRQ_SRCS-1:0] pend_q, pend_d;
    logic [IRQ_SRCS-1:0] en_q, en_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          dout_q, dout_d;
    logic                irq_n_q, irq_n_d;
    logic                reg_wr_q, reg_wr_d;
    logic [AR_W-1:0]     reg_addr_q, reg_addr_d;
    logic [15:0]         reg_data_q, reg_data_d;
    logic [15:0]         fifo_q [WFIFO_DEPTH];
    logic [15:0]         fifo_d [WFIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    rd_state_e           state_q, state_d;

    // decode
    a_sel_t              a_sel;
    logic                rd_act, wr_act;
    logic                rd_fire, wr_fire;
    logic                fifo_full, fifo_empty, busy;
    logic                commit, push, push_ok, pop, stat_clr;
    logic [15:0]         commit_data;
    logic [5:0]          pend_ext;

    // Access decode: only one strobe low counts; act on the first clock seen.
    always_comb begin
        a_sel      = a_sel_t'(bus.A);
        rd_act     = ~bus.CS_n & ~bus.RD_n &  bus.WR_n;
        wr_act     = ~bus.CS_n & ~bus.WR_n &  bus.RD_n;
        rd_fire    = rd_act & ~rd_seen_q;
        wr_fire    = wr_act & ~wr_seen_q;
        fifo_full  = (cnt_q == CNT_W'(WFIFO_DEPTH));
        fifo_empty = (cnt_q == '0);
        busy       = fifo_full | (state_q != RD_IDLE);
    end

    // Register file port, FIFO, IRQ aggregation and CPU read data.
    always_comb begin
        rd_seen_d   = rd_act;
        wr_seen_d   = wr_act;
        ar_d        = ar_q;
        lsb_d       = lsb_q;
        en_d        = en_q;
        dout_d      = dout_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        pend_ext    = '0;
        pend_ext[IRQ_SRCS-1:0] = pend_q;

        commit      = wr_fire & (a_sel == A_DATA_MSB);
        commit_data = {bus.D_in, lsb_q};
        push        = commit & (ar_q == AR_W'(VWR_REG));
        push_ok     = push & ~fifo_full;
        pop         = bus.vram_wr_ack & ~fifo_empty;
        stat_clr    = rd_fire & (a_sel == A_STATUS_REG);

        // CPU writes
        if (wr_fire && a_sel == A_ADDR_REG) ar_d = bus.D_in[AR_W-1:0];
        if (wr_fire && a_sel == A_DATA_LSB) lsb_d = bus.D_in;
        if (commit) begin
            reg_wr_d   = 1'b1;
            reg_addr_d = ar_q;
            reg_data_d = commit_data;
            if (ar_q == AR_W'(IRQ_EN_REG)) en_d = commit_data[IRQ_SRCS-1:0];
`ifdef VDC_HOST_AUTOINC_EN
            // streaming register keeps the address so the CPU can blast data
            if (ar_q != AR_W'(VWR_REG))
                ar_d = (ar_q == AR_W'(NUM_REGS-1)) ? '0 : ar_q + AR_W'(1);
`endif
        end

        // write FIFO: a push is only accepted if there was room before this cycle
        if (push_ok) begin
            fifo_d[wptr_q] = commit_data;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (pop) rptr_d = rptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // sticky flags: a new event in the clear cycle survives the clear
        pend_d  = (stat_clr ? '0 : pend_q) | bus.irq_src;
        ovf_d   = (stat_clr ? 1'b0 : ovf_q) | (push & fifo_full);
        irq_n_d = ~|(pend_d & en_d);

        // CPU reads return pre-access state
        if (rd_fire) begin
            case (a_sel)
                A_STATUS_REG: dout_d = {busy, ovf_q, pend_ext};
                A_ADDR_REG:   dout_d = 8'h00;
                A_DATA_LSB:   dout_d = rdlat_q[7:0];
                A_DATA_MSB:   dout_d = rdlat_q[15:8];
                default:      dout_d = 8'h00;
            endcase
        end
    end

    // VRAM read fetch: MSB read on the read register launches one request.
    always_comb begin
        state_d = state_q;
        rdlat_d = rdlat_q;
        case (state_q)
            RD_IDLE: begin
                if (rd_fire && a_sel == A_DATA_MSB && ar_q == AR_W'(VRR_REG))
                    state_d = RD_REQ;
            end
            RD_REQ: begin
                if (bus.vram_rd_ack) begin
                    rdlat_d = bus.vram_rd_data;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // State register for everything above.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_seen_q  <= 1'b0;
            wr_seen_q  <= 1'b0;
            ar_q       <= '0;
            lsb_q      <= '0;
            rdlat_q    <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
            irq_n_q    <= 1'b1;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            for (int i = 0; i < WFIFO_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            state_q    <= RD_IDLE;
        end else begin
            rd_seen_q  <= rd_seen_d;
            wr_seen_q  <= wr_seen_d;
            ar_q       <= ar_d;
            lsb_q      <= lsb_d;
            rdlat_q    <= rdlat_d;
            pend_q     <= pend_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            irq_n_q    <= irq_n_d;
            reg_wr_q   <= reg_wr_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign bus.D_out        = dout_q;
    assign bus.BUSY_n       = ~busy;
    assign bus.IRQ_n        = irq_n_q;
    assign bus.reg_wr       = reg_wr_q;
    assign bus.reg_addr     = reg_addr_q;
    assign bus.reg_data     = reg_data_q;
    assign bus.vram_wr_req  = ~fifo_empty;
    assign bus.vram_wr_data = fifo_q[rptr_q];
    assign bus.vram_rd_req  = (state_q == RD_REQ);
endmodule
